result_frame_tx: RTL and testbench
==================================

# result_frame_tx

Packs each FFT result set (three phase amplitudes plus coefficient, IEEE-754 single precision) into a fixed byte frame and streams it to a byte-wide transmit sink (UART or FIFO) over a valid/ready handshake. It sits downstream of the FFT block: the FFT produces results on a `dataOut` strobe, and this block is the hardware reader of those results. It replaces the bench's text-file dump on silicon.

## Interface
- `HEADER0`, default 8'hA5: first sync byte.
- `HEADER1`, default 8'h5A: second sync byte.
- `clk` input, 1 bit: system clock; all logic on its rising edge.
- `rstn` input, 1 bit: reset, asynchronous, active-low.
- `dataOut` input, 1 bit: FFT result strobe (level or pulse).
- `dataValid` input, 1 bit: FFT results qualified.
- `Amp0`, `Amp1`, `Amp2` input, 32 bits each: phase amplitudes A/B/C, float32.
- `Coff` input, 32 bits: coefficient, float32.
- `txReady` input, 1 bit: sink accepts a byte this cycle.
- `txValid` output, 1 bit: `txData` holds a valid byte.
- `txData` output, 8 bits: frame byte.
- `busy` output, 1 bit: a frame is in progress or a result is pending.
- `dropCount` output, 8 bits: saturating count of discarded result sets.

## Operation
- Capture event: `dataOut`=1 this cycle, `dataOut`=0 the previous cycle (registered edge detect; `dataOut` is 0 out of reset), and `dataValid`=1. An edge with `dataValid`=0 is ignored and is not counted.
- Storage: active slot plus one pending slot, each holding 128 bits. Amp0, Amp1, Amp2 and Coff are latched on the capture cycle.
- Frame byte order:
  - `HEADER0`, `HEADER1`.
  - SEQ (8-bit; 0 after reset; +1 per frame started; wraps 255→0).
  - 16 payload bytes: Amp0, Amp1, Amp2, Coff, each big-endian (MSB first).
  - CSUM, only when the macro is enabled (see Configuration).
- CSUM: sum modulo 256 of the SEQ byte and the 16 payload bytes. Headers are excluded.
- FSM states: IDLE, HDR0, HDR1, SEQ, PAYLOAD (4-bit byte index 0..15), CSUM.
  - IDLE→HDR0 when the active slot is loaded.
  - Each state advances only when `txValid && txReady`.
  - After the last byte is accepted: go to HDR0 if the pending slot is full (pending is promoted to active), else IDLE.
- Capture routing:
  - IDLE: capture loads the active slot.
  - Frame in progress, pending empty: capture loads pending.
  - Pending full and no slot freeing this cycle: the new result set is dropped and `dropCount` increments, saturating at 255.
- Simultaneous capture and last-byte accept:
  - Pending empty: the new set goes directly to the active slot; the next frame starts.
  - Pending full: pending is promoted and the new set takes the pending slot; no drop.
- `busy` = (state != IDLE) or pending full.
- Reset mid-frame: the frame is abandoned and the sink sees `txValid` drop asynchronously. All slots are cleared and SEQ returns to 0.

## Timing
- Reset values: `txValid`=0, `txData`=8'h00, `busy`=0, `dropCount`=0; internal SEQ=0, slots empty.
- Latency: capture in cycle N while IDLE → `txValid`=1 with `txData`=`HEADER0` in cycle N+1.
- Handshake:
  - Once `txValid` is high, `txData` is stable until accepted.
  - `txValid` never drops mid-frame.
  - One byte transfers per cycle in which `txReady`=1.
- Back-to-back frames: `HEADER0` is presented in the cycle after the last byte is accepted; `txValid` stays high.
- Minimum frame duration with `txReady` held high: 20 cycles with CSUM, 19 without.

## Configuration
- `RESULT_FRAME_CHECKSUM_EN` defined: CSUM state present; frame is 20 bytes.
- `RESULT_FRAME_CHECKSUM_EN` undefined: no CSUM state and no accumulator logic; PAYLOAD byte 15 is the last byte; frame is 19 bytes.

## Structure
- Package `result_frame_pkg` contains:
  - the FSM state enum;
  - default header constants;
  - `PAYLOAD_BYTES`=16;
  - the frame length localparam, conditional on the macro.
- Sub-module `result_slot_buffer`: active/pending 128-bit slots with load, promote and drop logic, and the `dropCount` saturation.
- The FSM, byte mux and checksum stay in the top module.

## Test plan
- Reset, then capture Amp0=32'h3F800000, Amp1=32'h40000000, Amp2=32'h40400000, Coff=32'h3DCCCCCD with `txReady`=1 → bytes A5 5A 00 3F 80 00 00 40 00 00 00 40 40 00 00 3D CC CC CD 21. `txValid` rises one cycle after capture.
- Same capture with `txReady` toggling 1/0 each cycle → identical byte sequence; `txData` is stable during every stall.
- Three captures 2 cycles apart with `txReady`=1 → frames with SEQ 00 and 01 are sent back-to-back; third capture is dropped; `dropCount`=1.
- Capture asserted in the same cycle as the last byte accept, pending empty → next frame's `HEADER0` appears the following cycle; `dropCount` stays 0.
- Assert `rstn` low at payload byte 5 → `txValid`=0 immediately; a fresh capture after release sends SEQ=00.
- 257 frames sent (single captures each with `txReady`=1) → SEQ wraps to 00 on frame 257; capture with `dataValid`=0 → no frame, `dropCount` unchanged.

Source files
------------

// File: rtl/result_frame_pkg.sv
// result_frame_pkg
//   Shared types and constants for the result frame transmitter.
//   Optional feature macro: RESULT_FRAME_CHECKSUM_EN
//     defined   -> frame ends with a CSUM byte (20 bytes per frame)
//     undefined -> no CSUM byte (19 bytes per frame)
//   Contents: FSM state enum, default sync header bytes, payload/frame sizes,
//   byte-select / checksum / saturating-increment helper functions.
package result_frame_pkg;

  localparam logic [7:0]  HEADER0_DEFAULT = 8'hA5;
  localparam logic [7:0]  HEADER1_DEFAULT = 8'h5A;
  localparam int unsigned PAYLOAD_BYTES   = 16;
  localparam int unsigned SLOT_BITS       = 128;
  localparam logic [3:0]  LAST_PAYLOAD_IDX = 4'(PAYLOAD_BYTES - 1);

`ifdef RESULT_FRAME_CHECKSUM_EN
  localparam int unsigned FRAME_BYTES = 20;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HDR0    = 3'd1,
    ST_HDR1    = 3'd2,
    ST_SEQ     = 3'd3,
    ST_PAYLOAD = 3'd4,
    ST_CSUM    = 3'd5
  } state_e;
`else
  localparam int unsigned FRAME_BYTES = 19;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HDR0    = 3'd1,
    ST_HDR1    = 3'd2,
    ST_SEQ     = 3'd3,
    ST_PAYLOAD = 3'd4
  } state_e;
`endif

  // Byte idx (0 = most significant) of a 128-bit slot; payload is big-endian.
  function automatic logic [7:0] payload_byte(input logic [127:0] slot,
                                              input logic [3:0]   idx);
    logic [127:0] shifted;
    shifted = slot << {idx, 3'b000};
    return shifted[127:120];
  endfunction

  // Running modulo-256 checksum step.
  function automatic logic [7:0] csum_add(input logic [7:0] acc,
                                          input logic [7:0] data);
    return acc + data;
  endfunction

  // 8-bit counter increment that sticks at 255.
  function automatic logic [7:0] sat_inc(input logic [7:0] cnt);
    return (cnt == 8'hFF) ? 8'hFF : (cnt + 8'd1);
  endfunction

endpackage

// File: rtl/result_frame_tx_result_slot_buffer.sv
// result_slot_buffer
//   Two-entry store for FFT result sets: an active slot (the set currently
//   being framed) and one pending slot (the next set to frame).
//   Ports:
//     clk, rstn          clock, asynchronous active-low reset
//     capture_i          a qualified result set is presented this cycle
//     release_i          the last byte of the active frame is accepted this cycle
//     capture_data_i     {Amp0, Amp1, Amp2, Coff}
//     active_data_o      contents of the active slot
//     pending_valid_o    pending slot holds a set
//     drop_count_o       saturating count of discarded result sets
//   The active slot is occupied exactly while the top-level FSM is outside
//   IDLE; the FSM makes the same decision from capture/release/pending.
module result_slot_buffer
  import result_frame_pkg::*;
(
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 capture_i,
  input  logic                 release_i,
  input  logic [SLOT_BITS-1:0] capture_data_i,
  output logic [SLOT_BITS-1:0] active_data_o,
  output logic                 pending_valid_o,
  output logic [7:0]           drop_count_o
);

  logic                 active_valid_q, active_valid_d;
  logic                 pending_valid_q, pending_valid_d;
  logic [SLOT_BITS-1:0] active_q, active_d;
  logic [SLOT_BITS-1:0] pending_q, pending_d;
  logic [7:0]           drop_q, drop_d;

  // Slot routing: load, promote and drop decisions for one cycle.
  always_comb begin
    active_valid_d  = active_valid_q;
    pending_valid_d = pending_valid_q;
    active_d        = active_q;
    pending_d       = pending_q;
    drop_d          = drop_q;
    case ({capture_i, release_i})
      2'b10: begin
        if (!active_valid_q) begin
          active_d       = capture_data_i;
          active_valid_d = 1'b1;
        end else if (!pending_valid_q) begin
          pending_d       = capture_data_i;
          pending_valid_d = 1'b1;
        end else begin
          // Both slots busy and nothing frees up: discard the new set.
          drop_d = sat_inc(drop_q);
        end
      end
      2'b01: begin
        if (pending_valid_q) begin
          active_d        = pending_q;
          pending_d       = {SLOT_BITS{1'b0}};
          pending_valid_d = 1'b0;
        end else begin
          active_valid_d = 1'b0;
        end
      end
      2'b11: begin
        // A slot frees this cycle, so the new set always fits.
        if (pending_valid_q) begin
          active_d  = pending_q;
          pending_d = capture_data_i;
        end else begin
          active_d = capture_data_i;
        end
      end
      default: begin
        active_valid_d = active_valid_q;
      end
    endcase
  end

  // Slot and drop-counter registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      active_valid_q  <= 1'b0;
      pending_valid_q <= 1'b0;
      active_q        <= {SLOT_BITS{1'b0}};
      pending_q       <= {SLOT_BITS{1'b0}};
      drop_q          <= 8'h00;
    end else begin
      active_valid_q  <= active_valid_d;
      pending_valid_q <= pending_valid_d;
      active_q        <= active_d;
      pending_q       <= pending_d;
      drop_q          <= drop_d;
    end
  end

  assign active_data_o   = active_q;
  assign pending_valid_o = pending_valid_q;
  assign drop_count_o    = drop_q;

endmodule

// File: rtl/result_frame_tx.sv
// result_frame_tx
//   Reads FFT result sets on the rising edge of dataOut (qualified by
//   dataValid) and streams each as a fixed byte frame:
//     HEADER0 HEADER1 SEQ Amp0[31:24]..Coff[7:0] [CSUM]
//   over a valid/ready byte interface.
//   Optional feature macro: RESULT_FRAME_CHECKSUM_EN (adds CSUM byte =
//   sum mod 256 of SEQ and the 16 payload bytes).
//   Ports:
//     clk, rstn                 clock, asynchronous active-low reset
//     dataOut, dataValid        FFT result strobe and qualifier
//     Amp0, Amp1, Amp2, Coff    float32 result words
//     txReady                   sink accepts txData this cycle
//     txValid, txData           registered byte stream
//     busy                      frame in progress or a set is pending
//     dropCount                 saturating count of discarded sets
module result_frame_tx
  import result_frame_pkg::*;
#(
  parameter logic [7:0] HEADER0 = HEADER0_DEFAULT,
  parameter logic [7:0] HEADER1 = HEADER1_DEFAULT
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        dataOut,
  input  logic        dataValid,
  input  logic [31:0] Amp0,
  input  logic [31:0] Amp1,
  input  logic [31:0] Amp2,
  input  logic [31:0] Coff,
  input  logic        txReady,
  output logic        txValid,
  output logic [7:0]  txData,
  output logic        busy,
  output logic [7:0]  dropCount
);

  state_e               state_q;
  logic                 data_out_q;
  logic [3:0]           idx_q;
  logic [7:0]           seq_q;
  logic                 tx_valid_q;
  logic [7:0]           tx_data_q;
`ifdef RESULT_FRAME_CHECKSUM_EN
  logic [7:0]           csum_q;
`endif

  logic                 capture_s;
  logic                 accept_s;
  logic                 last_s;
  logic                 release_s;
  logic                 restart_s;
  logic                 pending_valid_s;
  logic [SLOT_BITS-1:0] active_data_s;

  assign capture_s = dataOut & ~data_out_q & dataValid;
  assign accept_s  = tx_valid_q & txReady;
`ifdef RESULT_FRAME_CHECKSUM_EN
  assign last_s    = (state_q == ST_CSUM);
`else
  assign last_s    = (state_q == ST_PAYLOAD) && (idx_q == LAST_PAYLOAD_IDX);
`endif
  assign release_s = accept_s & last_s;
  // After the last byte another frame follows if a set is waiting or arriving.
  assign restart_s = pending_valid_s | capture_s;

  result_slot_buffer u_slots (
    .clk             (clk),
    .rstn            (rstn),
    .capture_i       (capture_s),
    .release_i       (release_s),
    .capture_data_i  ({Amp0, Amp1, Amp2, Coff}),
    .active_data_o   (active_data_s),
    .pending_valid_o (pending_valid_s),
    .drop_count_o    (dropCount)
  );

  // Strobe history for rising-edge detection.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data_out_q <= 1'b0;
    end else begin
      data_out_q <= dataOut;
    end
  end

  // Frame FSM with registered txValid/txData; each transition loads the byte
  // the new state presents, so txData holds steady while the sink stalls.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      idx_q      <= 4'd0;
      seq_q      <= 8'h00;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
`ifdef RESULT_FRAME_CHECKSUM_EN
      csum_q     <= 8'h00;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (capture_s) begin
            state_q    <= ST_HDR0;
            tx_valid_q <= 1'b1;
            tx_data_q  <= HEADER0;
          end
        end
        ST_HDR0: begin
          if (accept_s) begin
            state_q   <= ST_HDR1;
            tx_data_q <= HEADER1;
          end
        end
        ST_HDR1: begin
          if (accept_s) begin
            state_q   <= ST_SEQ;
            tx_data_q <= seq_q;
          end
        end
        ST_SEQ: begin
          if (accept_s) begin
            state_q   <= ST_PAYLOAD;
            idx_q     <= 4'd0;
            tx_data_q <= payload_byte(active_data_s, 4'd0);
            seq_q     <= seq_q + 8'd1;
`ifdef RESULT_FRAME_CHECKSUM_EN
            csum_q    <= tx_data_q;
`endif
          end
        end
        ST_PAYLOAD: begin
          if (accept_s) begin
            if (idx_q == LAST_PAYLOAD_IDX) begin
`ifdef RESULT_FRAME_CHECKSUM_EN
              state_q   <= ST_CSUM;
              tx_data_q <= csum_add(csum_q, tx_data_q);
`else
              if (restart_s) begin
                state_q   <= ST_HDR0;
                tx_data_q <= HEADER0;
              end else begin
                state_q    <= ST_IDLE;
                tx_valid_q <= 1'b0;
                tx_data_q  <= 8'h00;
              end
`endif
            end else begin
              idx_q     <= idx_q + 4'd1;
              tx_data_q <= payload_byte(active_data_s, idx_q + 4'd1);
`ifdef RESULT_FRAME_CHECKSUM_EN
              csum_q    <= csum_add(csum_q, tx_data_q);
`endif
            end
          end
        end
`ifdef RESULT_FRAME_CHECKSUM_EN
        ST_CSUM: begin
          if (accept_s) begin
            if (restart_s) begin
              state_q   <= ST_HDR0;
              tx_data_q <= HEADER0;
            end else begin
              state_q    <= ST_IDLE;
              tx_valid_q <= 1'b0;
              tx_data_q  <= 8'h00;
            end
          end
        end
`endif
        default: begin
          state_q    <= ST_IDLE;
          tx_valid_q <= 1'b0;
          tx_data_q  <= 8'h00;
        end
      endcase
    end
  end

  assign txValid = tx_valid_q;
  assign txData  = tx_data_q;
  assign busy    = (state_q != ST_IDLE) | pending_valid_s;

endmodule

// File: tb/tb_result_frame_tx.sv
// tb_result_frame_tx
//   Self-checking bench for result_frame_tx. A byte-queue reference model
//   predicts txValid/txData/busy/dropCount every cycle from the stimulus.
module tb_result_frame_tx;

  localparam logic [7:0] H0 = 8'hA5;
  localparam logic [7:0] H1 = 8'h5A;
`ifdef RESULT_FRAME_CHECKSUM_EN
  localparam int FRAME_LEN = 20;
`else
  localparam int FRAME_LEN = 19;
`endif

  logic        clk = 1'b0;
  logic        rstn;
  logic        dataOut;
  logic        dataValid;
  logic [31:0] Amp0, Amp1, Amp2, Coff;
  logic        txReady;
  logic        txValid;
  logic [7:0]  txData;
  logic        busy;
  logic [7:0]  dropCount;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0] exp_q[$];
  bit         last_q[$];
  int         frames;
  logic [7:0] m_seq;
  logic [7:0] m_drop;
  logic       m_prev;
  logic [7:0] seen_q[$];

  logic [127:0] vec_data = {32'h3F800000, 32'h40000000, 32'h40400000, 32'h3DCCCCCD};
  logic [7:0]   vec_exp [20] = '{8'hA5, 8'h5A, 8'h00, 8'h3F, 8'h80, 8'h00, 8'h00,
                                 8'h40, 8'h00, 8'h00, 8'h00, 8'h40, 8'h40, 8'h00,
                                 8'h00, 8'h3D, 8'hCC, 8'hCC, 8'hCD, 8'h21};

  // Free-running clock
  always #5 clk = ~clk;

  result_frame_tx dut (
    .clk       (clk),
    .rstn      (rstn),
    .dataOut   (dataOut),
    .dataValid (dataValid),
    .Amp0      (Amp0),
    .Amp1      (Amp1),
    .Amp2      (Amp2),
    .Coff      (Coff),
    .txReady   (txReady),
    .txValid   (txValid),
    .txData    (txData),
    .busy      (busy),
    .dropCount (dropCount)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Append the full expected frame for one accepted result set.
  task automatic model_push(input logic [127:0] data);
    logic [7:0] sum;
    logic [7:0] b;
    sum = m_seq;
    exp_q.push_back(H0);    last_q.push_back(1'b0);
    exp_q.push_back(H1);    last_q.push_back(1'b0);
    exp_q.push_back(m_seq); last_q.push_back(1'b0);
    for (int i = 0; i < 16; i++) begin
      b = data[127 - 8*i -: 8];
      sum = sum + b;
      exp_q.push_back(b);
`ifdef RESULT_FRAME_CHECKSUM_EN
      last_q.push_back(1'b0);
`else
      last_q.push_back(i == 15);
`endif
    end
`ifdef RESULT_FRAME_CHECKSUM_EN
    exp_q.push_back(sum); last_q.push_back(1'b1);
`endif
    m_seq = m_seq + 8'd1;
    frames++;
  endtask

  // One clock cycle: drive, compare at negedge, advance model, cross posedge.
  task automatic step(input logic d_out, input logic d_valid, input logic ready,
                      input logic [127:0] data);
    dataOut   = d_out;
    dataValid = d_valid;
    txReady   = ready;
    {Amp0, Amp1, Amp2, Coff} = data;
    @(negedge clk);
    check_eq("txValid", 32'(txValid), 32'(exp_q.size() > 0));
    if (exp_q.size() > 0) check_eq("txData", 32'(txData), 32'(exp_q[0]));
    check_eq("busy", 32'(busy), 32'(frames > 0));
    check_eq("dropCount", 32'(dropCount), 32'(m_drop));
    if (txValid && ready) seen_q.push_back(txData);
    if (exp_q.size() > 0 && ready) begin
      void'(exp_q.pop_front());
      if (last_q.pop_front()) frames--;
    end
    if (d_out && !m_prev && d_valid) begin
      if (frames < 2) model_push(data);
      else if (m_drop != 8'hFF) m_drop = m_drop + 8'd1;
    end
    m_prev = d_out;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b1, 128'd0);
  endtask

  // Asynchronous reset assertion mid-cycle; outputs must clear at once.
  task automatic apply_reset();
    rstn = 1'b0; dataOut = 1'b0; dataValid = 1'b0; txReady = 1'b0;
    #1;
    check_eq("rst_txValid", 32'(txValid), 32'd0);
    check_eq("rst_txData", 32'(txData), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_dropCount", 32'(dropCount), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete(); last_q.delete();
    frames = 0; m_seq = 8'h00; m_drop = 8'h00; m_prev = 1'b0;
  endtask

  // Main stimulus sequence
  initial begin
    rstn = 1'b0; dataOut = 1'b0; dataValid = 1'b0; txReady = 1'b0;
    {Amp0, Amp1, Amp2, Coff} = 128'd0;
    frames = 0; m_seq = 8'h00; m_drop = 8'h00; m_prev = 1'b0;
    apply_reset();

    // Known vector, sink always ready
    seen_q.delete();
    step(1'b1, 1'b1, 1'b1, vec_data);
    idle(FRAME_LEN + 4);
    check_eq("vec_len", 32'(seen_q.size()), 32'(FRAME_LEN));
    for (int i = 0; i < FRAME_LEN; i++)
      if (i < seen_q.size()) check_eq("vec_byte", 32'(seen_q[i]), 32'(vec_exp[i]));

    // Known vector, sink toggling ready
    apply_reset();
    seen_q.delete();
    step(1'b1, 1'b1, 1'b0, vec_data);
    for (int k = 0; k < 2 * FRAME_LEN + 4; k++) step(1'b0, 1'b0, k[0] ? 1'b0 : 1'b1, 128'd0);
    check_eq("stall_len", 32'(seen_q.size()), 32'(FRAME_LEN));
    for (int i = 0; i < FRAME_LEN; i++)
      if (i < seen_q.size()) check_eq("stall_byte", 32'(seen_q[i]), 32'(vec_exp[i]));

    // Three captures two cycles apart: third dropped
    apply_reset();
    step(1'b1, 1'b1, 1'b1, rand128());
    step(1'b0, 1'b0, 1'b1, 128'd0);
    step(1'b1, 1'b1, 1'b1, rand128());
    step(1'b0, 1'b0, 1'b1, 128'd0);
    step(1'b1, 1'b1, 1'b1, rand128());
    idle(2 * FRAME_LEN + 4);
    check_eq("drop_three", 32'(dropCount), 32'd1);

    // Capture coincident with last-byte accept, pending empty
    apply_reset();
    step(1'b1, 1'b1, 1'b1, rand128());
    idle(FRAME_LEN - 1);
    step(1'b1, 1'b1, 1'b1, rand128());
    check_eq("b2b_valid", 32'(txValid), 32'd1);
    check_eq("b2b_hdr", 32'(txData), 32'(H0));
    idle(FRAME_LEN + 2);
    check_eq("b2b_drop", 32'(dropCount), 32'd0);

    // Reset during payload byte 5, then fresh frame restarts SEQ at 0
    apply_reset();
    step(1'b1, 1'b1, 1'b1, rand128());
    idle(9);
    apply_reset();
    step(1'b1, 1'b1, 1'b1, rand128());
    idle(FRAME_LEN + 2);

    // Randomized traffic with stalls, pending and drops
    apply_reset();
    for (int k = 0; k < 3000; k++)
      step(($urandom_range(0, 3) == 0), ($urandom_range(0, 7) != 0),
           ($urandom_range(0, 3) != 0), rand128());
    idle(3 * FRAME_LEN);

    // 257 frames: SEQ wraps to 0 on the last one
    apply_reset();
    for (int f = 0; f < 257; f++) begin
      if (f == 256) seen_q.delete();
      step(1'b1, 1'b1, 1'b1, rand128());
      idle(FRAME_LEN + 1);
    end
    check_eq("wrap_seq", 32'(seen_q.size() > 2 ? seen_q[2] : 8'hEE), 32'd0);

    // Edge without dataValid: ignored, not counted
    step(1'b1, 1'b0, 1'b1, rand128());
    idle(4);
    check_eq("nv_busy", 32'(busy), 32'd0);
    check_eq("nv_drop", 32'(dropCount), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
